// File: rtl/ps2_key_event_ctrl_if.sv
// rtl/ps2_key_event_ctrl_if.sv - scan-byte input, event FIFO and status bundle for ps2_key_event_ctrl
interface ps2_key_event_ctrl_if #(
  parameter int FIFO_DEPTH_LOG2 = 3
);
  logic [7:0]               i_ps2_byte;
  logic                     i_ps2_byte_valid;
  logic                     i_evt_rd;
  logic                     i_clear_overflow;
  logic                     o_evt_valid;
  logic [4:0]               o_evt_data;
  logic [FIFO_DEPTH_LOG2:0] o_evt_count;
  logic [15:0]              o_held;
  logic                     o_overflow;

  // Producer side: PS/2 receiver plus processor register path
  modport master (
    output i_ps2_byte, i_ps2_byte_valid, i_evt_rd, i_clear_overflow,
    input  o_evt_valid, o_evt_data, o_evt_count, o_held, o_overflow
  );

  // Controller side
  modport slave (
    input  i_ps2_byte, i_ps2_byte_valid, i_evt_rd, i_clear_overflow,
    output o_evt_valid, o_evt_data, o_evt_count, o_held, o_overflow
  );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - PS/2 set-2 scan bytes to debounced game-key make/break events with FWFT queue
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ps2_key_event_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [7:0]    BYTE_BRK  = 8'hF0;
  localparam logic [7:0]    BYTE_EXT  = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BRK    = 2'd1,
    ST_EXT    = 2'd2,
    ST_EXTBRK = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [TW-1:0]              r_tmo_cnt;
  logic                       w_tmo_hit;

  logic                       w_key_hit;
  logic [3:0]                 w_key_idx;
  logic                       w_is_make;
  logic                       w_is_break;

  logic [15:0]                r_held;
  logic                       w_push;
  logic [4:0]                 w_push_data;

  logic [4:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_wr;
  logic                       w_drop;
  logic                       r_overflow;

  // Map a scan code to its game-key index; anything else is not a game key
  always_comb begin
    w_key_hit = 1'b1;
    w_key_idx = 4'd0;
    case (bus.i_ps2_byte)
      8'h33:   w_key_idx = 4'd0;
      8'h3B:   w_key_idx = 4'd1;
      8'h42:   w_key_idx = 4'd2;
      8'h4B:   w_key_idx = 4'd3;
      8'h16:   w_key_idx = 4'd4;
      8'h1E:   w_key_idx = 4'd5;
      8'h26:   w_key_idx = 4'd6;
      8'h25:   w_key_idx = 4'd7;
      8'h2E:   w_key_idx = 4'd8;
      8'h2C:   w_key_idx = 4'd9;
      8'h1C:   w_key_idx = 4'd10;
      8'h1B:   w_key_idx = 4'd11;
      8'h23:   w_key_idx = 4'd12;
      8'h2B:   w_key_idx = 4'd13;
      8'h2D:   w_key_idx = 4'd14;
      8'h4D:   w_key_idx = 4'd15;
      default: w_key_hit = 1'b0;
    endcase
  end

  // Prefix FSM next state and make/break qualification
  always_comb begin
    w_state_nxt = r_state;
    w_is_make   = 1'b0;
    w_is_break  = 1'b0;
    w_tmo_hit   = (r_state != ST_IDLE) && !bus.i_ps2_byte_valid && (r_tmo_cnt == TMO_LAST);
    if (bus.i_ps2_byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_ps2_byte == BYTE_BRK) begin
            w_state_nxt = ST_BRK;
          end else if (bus.i_ps2_byte == BYTE_EXT) begin
            w_state_nxt = ST_EXT;
          end else begin
            w_is_make = w_key_hit;
          end
        end
        ST_BRK: begin
          // A second prefix right after F0 is a protocol error: drop it
          w_state_nxt = ST_IDLE;
          if ((bus.i_ps2_byte != BYTE_BRK) && (bus.i_ps2_byte != BYTE_EXT)) begin
            w_is_break = w_key_hit;
          end
        end
        ST_EXT: begin
          w_state_nxt = (bus.i_ps2_byte == BYTE_BRK) ? ST_EXTBRK : ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else if (w_tmo_hit) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Idle cycles spent waiting for the byte that follows a prefix
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state == ST_IDLE) || bus.i_ps2_byte_valid || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  // Only a state change of the key produces an event; repeats are filtered here
  assign w_push      = (w_is_make && !r_held[w_key_idx]) || (w_is_break && r_held[w_key_idx]);
  assign w_push_data = {w_is_make, w_key_idx};

  // Held bitmap follows the physical key even when the event itself is dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_held <= '0;
    end else if (w_is_make) begin
      r_held[w_key_idx] <= 1'b1;
    end else if (w_is_break) begin
      r_held[w_key_idx] <= 1'b0;
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = bus.i_evt_rd && !w_empty;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // Event storage and write pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= w_push_data;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on each accepted pop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous write and pop leaves the count unchanged
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.i_clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.o_evt_valid = !w_empty;
  assign bus.o_evt_data  = w_empty ? 5'd0 : r_mem[r_rd_ptr];
  assign bus.o_evt_count = r_count;
  assign bus.o_held      = r_held;
  assign bus.o_overflow  = r_overflow;

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sequences raw PS/2 scan-code bytes from the PS/2 receiver into debounced key make/break events for the game keys (h j k l 1-5 t a s d f r p). Tracks PS/2 set-2 prefixes (E0 extended, F0 break) with an FSM and suppresses typematic repeats. Maintains a per-key held bitmap and queues events in a small first-word-fall-through FIFO. The processor drains the FIFO through its memory-mapped keyboard register path.

## Interface
- FIFO_DEPTH_LOG2, default 3: FIFO holds 2^FIFO_DEPTH_LOG2 events (8).
- TIMEOUT_CYCLES, default 50000: maximum cycles allowed between a prefix byte and its follow-up byte.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- ps2_byte  in  8  completed scan-code byte from the PS/2 receiver.
- ps2_byte_valid  in  1  one-cycle strobe; ps2_byte is valid this cycle.
- evt_rd  in  1  pops the FIFO head when evt_valid is high.
- clear_overflow  in  1  clears the overflow flag.
- evt_valid  out  1  FIFO is non-empty.
- evt_data  out  5  FIFO head: bit 4 = 1 for make, 0 for break; bits 3:0 = key index.
- evt_count  out  FIFO_DEPTH_LOG2+1  number of queued events.
- held  out  16  held[i] = 1 while key i is down.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- Key index map (index:code): 0:33 h, 1:3B j, 2:42 k, 3:4B l, 4:16 1, 5:1E 2, 6:26 3, 7:25 4, 8:2E 5, 9:2C t, 10:1C a, 11:1B s, 12:23 d, 13:2B f, 14:2D r, 15:4D p.
- Any other code is unmapped and is silently discarded.
- FSM states are IDLE, BRK, EXT and EXTBRK. Transitions happen only on a cycle where ps2_byte_valid is high, except for timeout.
- IDLE:
  - F0 -> BRK.
  - E0 -> EXT.
  - Mapped code -> make processing, stay in IDLE.
  - Anything else -> stay in IDLE.
- BRK:
  - F0 or E0 -> discard, go to IDLE (protocol error).
  - Any other byte -> break processing, go to IDLE.
- EXT:
  - F0 -> EXTBRK.
  - Any other byte -> discard, go to IDLE. Extended keys are not mapped.
- EXTBRK: any byte -> discard, go to IDLE.
- Make processing for key i:
  - If held[i] = 0: set held[i] and push {1,i}.
  - If held[i] = 1: typematic repeat; no push, no change.
- Break processing for key i:
  - If held[i] = 1: clear held[i] and push {0,i}.
  - If held[i] = 0: no push, no change.
- held updates even when the push is dropped on a full FIFO, so held always tracks the physical key state.
- FIFO rules:
  - Push when full is dropped and sets overflow.
  - Push and pop in the same cycle while full: the pop frees the slot, the push is accepted, and evt_count is unchanged.
  - Push and pop in the same cycle while empty is impossible, because evt_valid = 0 makes evt_rd ignored.
  - evt_rd while empty is ignored.
  - Read and write pointers wrap modulo 2^FIFO_DEPTH_LOG2.
- overflow:
  - clear_overflow clears it.
  - If a drop and clear_overflow occur in the same cycle, set wins.
- Timeout counter:
  - Counts every cycle spent in BRK, EXT or EXTBRK with ps2_byte_valid low.
  - Resets to 0 on any valid byte and whenever the FSM is in IDLE.
  - On reaching TIMEOUT_CYCLES-1, the FSM returns to IDLE the next edge and the pending prefix is discarded.

## Timing
- Reset values:
  - FSM = IDLE; timeout counter = 0.
  - FIFO empty: evt_valid = 0, evt_count = 0, evt_data = 0.
  - held = 0; overflow = 0.
- Reset mid-sequence, for example after F0, returns to IDLE. The next mapped byte is then treated as a make.
- Latency: a valid byte sampled at edge N updates held, and the pushed event is visible at the FIFO head, after edge N.
  - evt_valid rises in cycle N+1 when the FIFO was empty.
- evt_data is combinational from the head entry (first-word fall-through).
- A pop at edge M exposes the next entry, or drops evt_valid, after edge M.
- Back-to-back valid bytes on consecutive cycles must be accepted without loss.

## Test plan
- Make then break: bytes 33, F0, 33.
  - Required: events {1,0} then {0,0}; held[0] goes 1 then 0; evt_count reaches 2.
- Typematic repeat: bytes 1C, 1C, 1C.
  - Required: exactly one event {1,10}; held[10] = 1.
- Extended and error handling: bytes E0 75, then E0 F0 75, then F0 F0 then 4D.
  - Required: no events from the extended sequences.
  - The final 4D is treated as a make: event {1,15}.
- Overflow: 9 distinct makes with no reads.
  - Required: evt_count = 8; overflow = 1; held shows all 9 keys.
  - Then pop plus push in the same cycle: evt_count stays 8.
  - clear_overflow drops overflow to 0.
- Timeout: byte F0, then idle for TIMEOUT_CYCLES cycles (set to 16 in the bench), then 33.
  - Required: 33 is treated as a make {1,0}, not a break.
- Reset after F0: apply reset, then byte 42.
  - Required: event {1,2}; all other state at its reset values.
